ue_tcam_rmw: RTL and testbench
==============================

# ue_tcam_rmw

Parametrised BRAM-based ternary CAM with full read-modify-write update and entry deletion. A write with an arbitrary don't-care mask walks every sub-word address of the target layer, so overwriting an entry leaves no stale match bits. Lookups are pipelined, qualified by a per-entry valid bit, and resolved by a lowest-index priority encoder. The block is a drop-in upgrade for the single-cycle-write TCAM in the packet-classification datapath.

## Interface
- DEPTH, 512: number of entries; DEPTH % L == 0
- WIDTH, 36: key width; WIDTH % N == 0
- L, 4: layers (entry groups); SA_DEPTH = DEPTH/L entries per layer
- N, 4: sub-words per key; SW = WIDTH/N bits each; each BRAM is 2^SW x SA_DEPTH
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wReq  in  1  update request
- wReady  out  1  update accepted when wReq && wReady
- wOp  in  1  0 = insert/overwrite, 1 = delete
- wAddr  in  clog2(DEPTH)  entry index
- wPatt  in  WIDTH  pattern
- wMask  in  WIDTH  1 = don't-care bit
- wDone  out  1  one-cycle pulse when update completes
- mValid  in  1  lookup request
- mReady  out  1  lookup accepted when mValid && mReady
- mPatt  in  WIDTH  search key
- mOutValid  out  1  result valid pulse
- match  out  1  any valid entry matched
- mAddr  out  clog2(DEPTH)  lowest matching entry index; 0 when no match

## Operation
- Entry e lives in layer e / SA_DEPTH, bit position e % SA_DEPTH.
- Each BRAM has its own address and data-in; the L x N array has 1-cycle registered read latency.
- Valid register: DEPTH flops, cleared by reset.
- FSM states: IDLE, RD, WR, FIN. Address counter a: SW bits.
  - IDLE: wReady = 1. On wReq, latch wOp, wAddr, wPatt, wMask; set a = 0; go to RD.
  - RD: drive a to all N BRAMs of the target layer; go to WR.
  - WR: for each sub-word j, write dout_j with bit b replaced by new_j.
    - new_j = !wOp && ((a ^ wPatt_j) & ~wMask_j) == 0
    - Other layers are not written.
    - If a is at its maximum, go to FIN; otherwise increment a and go to RD.
  - FIN: valid[wAddr] <= !wOp; wDone = 1; go to IDLE.
- Delete writes 0 to bit b in every row, regardless of wPatt/wMask.
- Arbitration:
  - mReady = (state == IDLE) && !wReq, so a simultaneous request gives the update priority.
  - Lookups are blocked for the whole update.
- Lookup:
  - Drives the mPatt sub-words to every layer's BRAM j.
  - pma = AND over the N douts per layer, concatenated with layer 0 in the LSBs, then ANDed with valid.
  - match = |pma; mAddr = index of the lowest set bit.
- Reset:
  - Clears valid, FSM to IDLE, lookup pipeline empty.
  - BRAM contents are undefined but masked by valid.
  - A later insert rewrites all 2^SW rows of that entry's bit, so stale BRAM data never leaks.

## Timing
- Reset values:
  - wReady = 1, mReady = 1 (when wReq is low).
  - wDone, mOutValid, match, mAddr = 0.
- Lookup:
  - Accepted at cycle t; BRAM read at t+1; result registered.
  - mOutValid, match and mAddr are valid in cycle t+2 and held until the next result.
  - Throughput is 1 per cycle while idle.
- Update:
  - Accepted at cycle 0.
  - RD/WR pairs occupy cycles 1 .. 2*2^SW.
  - FIN (wDone = 1) at cycle 2*2^SW+1.
  - wReady returns high at 2*2^SW+2.
  - Defaults give 1025 busy cycles.
- A lookup accepted in the same cycle the update is accepted cannot occur.
- A lookup accepted one cycle earlier completes with pre-update contents.
- A lookup accepted after FIN sees the new contents and valid bit.
- Asynchronous reset mid-update aborts it; the entry stays invalid and wReady rises immediately.
- wReq while busy is ignored. The requester holds wReq until wReady.

## Test plan
Parameters for all scenarios: DEPTH=16, WIDTH=8, L=2, N=2, so SW=4, SA_DEPTH=8 and an update is 33 busy cycles.
- Post-reset lookup 0xA5 -> mOutValid 2 cycles later, match=0, mAddr=0.
- Insert e5 patt 0xA5 mask 0x00, with mValid high in the same cycle -> mReady=0, wReady low 33 cycles, wDone at cycle 33. Then lookup 0xA5 -> match=1, mAddr=5; lookup 0xA4 -> match=0.
- Add e9 patt 0xA0 mask 0x0F and e3 patt 0xA5 mask 0x00 -> lookup 0xA5 gives mAddr=3; 0xAF gives mAddr=9; 0xB5 gives match=0.
- Overwrite e3 with patt 0x11 mask 0x00 -> lookup 0xA5 gives mAddr=5; 0x11 gives mAddr=3.
- Delete e5 -> lookup 0xA5 gives mAddr=9. Delete e9 -> lookup 0xA5 gives match=0.
- Insert e2 patt 0xAF mask 0x00, and pull rst_n low at update cycle 10 -> all outputs at reset values asynchronously. After release, lookup 0xAF gives match=0. Re-insert e2 completes in 33 cycles; lookup 0xAF then gives mAddr=2.

Source files
------------

// File: rtl/ue_tcam_rmw.sv
// ue_tcam_rmw: BRAM-based ternary CAM with read-modify-write update and delete.
// Entry e is bit (e % SA_DEPTH) of layer (e / SA_DEPTH). Each layer has N BRAMs,
// one per key sub-word, each 2^SW rows x SA_DEPTH bits. An update walks all
// 2^SW rows of the target layer, so no stale match bits survive an overwrite.
module ue_tcam_rmw #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 36,
    parameter int L     = 4,
    parameter int N     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wReq,
    output logic                     wReady,
    input  logic                     wOp,
    input  logic [$clog2(DEPTH)-1:0] wAddr,
    input  logic [WIDTH-1:0]         wPatt,
    input  logic [WIDTH-1:0]         wMask,
    output logic                     wDone,
    input  logic                     mValid,
    output logic                     mReady,
    input  logic [WIDTH-1:0]         mPatt,
    output logic                     mOutValid,
    output logic                     match,
    output logic [$clog2(DEPTH)-1:0] mAddr
);
    localparam int SA_DEPTH = DEPTH / L;
    localparam int SW       = WIDTH / N;
    localparam int ROWS     = 1 << SW;
    localparam int AW       = $clog2(DEPTH);
    localparam int BW       = (SA_DEPTH > 1) ? $clog2(SA_DEPTH) : 1;
    localparam int LW       = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SW-1:0]       r_a;
    logic                r_op;
    logic [AW-1:0]       r_addr;
    logic [WIDTH-1:0]    r_patt;
    logic [WIDTH-1:0]    r_mask;
    logic [DEPTH-1:0]    r_valid;
    logic                r_lk_v;
    logic                r_out_valid;
    logic                r_match;
    logic [AW-1:0]       r_maddr;

    logic [LW-1:0]       w_layer;
    logic [BW-1:0]       w_bit;
    logic [N-1:0]        w_new;
    logic [SW-1:0]       w_baddr [N];
    logic [SA_DEPTH-1:0] w_dout [L][N];
    logic [DEPTH-1:0]    w_pma;
    logic [AW-1:0]       w_idx;

    // Target layer and bit position of the entry being updated
    assign w_layer = LW'(int'(r_addr) / SA_DEPTH);
    assign w_bit   = BW'(int'(r_addr) % SA_DEPTH);

    // Lookups are only accepted when idle and no update is contending
    assign mReady    = (r_state == IDLE) && !wReq;
    assign mOutValid = r_out_valid;
    assign match     = r_match;
    assign mAddr     = r_maddr;

    // Update FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Update FSM next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        wReady       = 1'b0;
        wDone        = 1'b0;
        case (r_state)
            IDLE: begin
                wReady = 1'b1;
                if (wReq) w_state_next = RD;
            end
            RD:  w_state_next = WR;
            WR:  w_state_next = (r_a == '1) ? FIN : RD;
            FIN: begin
                wDone        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the update request and step the row counter once per RD/WR pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_op   <= 1'b0;
            r_addr <= '0;
            r_patt <= '0;
            r_mask <= '0;
        end else if (r_state == IDLE && wReq) begin
            r_a    <= '0;
            r_op   <= wOp;
            r_addr <= wAddr;
            r_patt <= wPatt;
            r_mask <= wMask;
        end else if (r_state == WR) begin
            r_a <= r_a + SW'(1);
        end
    end

    // Entry valid bits change only when an update completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_valid <= '0;
        else if (r_state == FIN)   r_valid[r_addr] <= !r_op;
    end

    genvar gi, gj;
    for (gj = 0; gj < N; gj++) begin : g_sub
        // Row r of sub-word j matches when it agrees with the pattern on all cared bits
        assign w_new[gj]   = !r_op &&
            (((r_a ^ r_patt[gj*SW +: SW]) & ~r_mask[gj*SW +: SW]) == '0);
        // Lookups index by key sub-word; updates sweep the row counter
        assign w_baddr[gj] = (r_state == IDLE) ? mPatt[gj*SW +: SW] : r_a;
    end

    for (gi = 0; gi < L; gi++) begin : g_layer
        for (gj = 0; gj < N; gj++) begin : g_bram
            logic [SA_DEPTH-1:0] r_mem [ROWS];
            logic [SA_DEPTH-1:0] r_dout;
            logic [SA_DEPTH-1:0] w_wdata;
            logic                w_we;

            assign w_we = (r_state == WR) && (w_layer == LW'(gi));

            // Row read in RD with only the target entry's bit replaced
            always_comb begin
                w_wdata        = r_dout;
                w_wdata[w_bit] = w_new[gj];
            end

            // Block RAM with registered read
            always_ff @(posedge clk) begin
                if (w_we) r_mem[r_a] <= w_wdata;
                r_dout <= r_mem[w_baddr[gj]];
            end

            assign w_dout[gi][gj] = r_dout;
        end

        logic [SA_DEPTH-1:0] w_and;
        // An entry in this layer matches only if every sub-word BRAM agrees
        always_comb begin
            w_and = '1;
            for (int j = 0; j < N; j++) w_and = w_and & w_dout[gi][j];
        end
        assign w_pma[gi*SA_DEPTH +: SA_DEPTH] = w_and & r_valid[gi*SA_DEPTH +: SA_DEPTH];
    end

    // Lowest-index priority encoder; index 0 when nothing matches
    always_comb begin
        w_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_pma[i]) w_idx = AW'(i);
        end
    end

    // Two-stage lookup pipeline: BRAM read, then registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lk_v      <= 1'b0;
            r_out_valid <= 1'b0;
            r_match     <= 1'b0;
            r_maddr     <= '0;
        end else begin
            r_lk_v      <= mValid && mReady;
            r_out_valid <= r_lk_v;
            if (r_lk_v) begin
                r_match <= |w_pma;
                r_maddr <= w_idx;
            end
        end
    end
endmodule

// File: tb/tb_ue_tcam_rmw.sv
// Testbench for ue_tcam_rmw: directed scenarios plus randomized updates and
// lookups, checked by a scoreboard fed from a behavioural TCAM model.
module tb_ue_tcam_rmw;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int L     = 2;
    localparam int N     = 2;
    localparam int AW    = 4;
    localparam int BUSY  = 33;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wReq = 1'b0;
    logic             wOp = 1'b0;
    logic [AW-1:0]    wAddr = '0;
    logic [WIDTH-1:0] wPatt = '0;
    logic [WIDTH-1:0] wMask = '0;
    logic             mValid = 1'b0;
    logic [WIDTH-1:0] mPatt = '0;
    logic             wReady, wDone, mReady, mOutValid, match;
    logic [AW-1:0]    mAddr;

    always #5 clk = ~clk;

    ue_tcam_rmw #(.DEPTH(DEPTH), .WIDTH(WIDTH), .L(L), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .wReq(wReq), .wReady(wReady), .wOp(wOp), .wAddr(wAddr),
        .wPatt(wPatt), .wMask(wMask), .wDone(wDone),
        .mValid(mValid), .mReady(mReady), .mPatt(mPatt),
        .mOutValid(mOutValid), .match(match), .mAddr(mAddr)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic          m;
        logic [AW-1:0] a;
        int            due;
    } exp_t;
    exp_t sb[$];

    // Behavioural model: a plain table of entries
    logic             m_valid [DEPTH];
    logic [WIDTH-1:0] m_patt  [DEPTH];
    logic [WIDTH-1:0] m_mask  [DEPTH];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW:0] ref_lookup(input logic [WIDTH-1:0] key);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && (((key ^ m_patt[i]) & ~m_mask[i]) == '0))
                return {1'b1, AW'(i)};
        end
        return '0;
    endfunction

    // Monitor: every result is popped and compared against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mOutValid) begin
            if (sb.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("lk_latency", cyc, e.due);
                check("lk_match", match, e.m);
                check("lk_addr", mAddr, e.a);
                $display("[TB] lookup result match=%0d addr=%0d (exp %0d/%0d)", match, mAddr, e.m, e.a);
            end
        end
    end

    task automatic lookup(input logic [WIDTH-1:0] key, input bit use_model,
                          input logic em, input logic [AW-1:0] ea);
        exp_t        e;
        logic [AW:0] r;
        @(negedge clk);
        mValid = 1'b1;
        mPatt  = key;
        #1;
        check("mReady_idle", mReady, 1);
        r = ref_lookup(key);
        if (use_model) begin
            e.m = r[AW];
            e.a = r[AW-1:0];
        end else begin
            e.m = em;
            e.a = ea;
        end
        e.due = cyc + 2;
        if (mReady) sb.push_back(e);
        @(posedge clk);
        #1 mValid = 1'b0;
    endtask

    task automatic update(input logic op, input logic [AW-1:0] addr,
                          input logic [WIDTH-1:0] patt, input logic [WIDTH-1:0] mask,
                          input bit with_lk);
        int n;
        int low;
        @(negedge clk);
        wReq   = 1'b1;
        wOp    = op;
        wAddr  = addr;
        wPatt  = patt;
        wMask  = mask;
        mValid = with_lk;
        mPatt  = patt;
        #1;
        check("wReady_idle", wReady, 1);
        if (with_lk) check("mReady_blocked", mReady, 0);
        @(posedge clk);
        #1;
        wReq   = 1'b0;
        mValid = 1'b0;
        wPatt  = WIDTH'($urandom);
        wMask  = WIDTH'($urandom);
        wAddr  = AW'($urandom);
        low = 0;
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (!wReady) low++;
            if (wDone) break;
        end
        check("wDone_cycle", n, BUSY);
        check("wReady_low_cycles", low, BUSY);
        @(negedge clk);
        check("wReady_back", wReady, 1);
        check("wDone_pulse", wDone, 0);
        $display("[TB] update op=%0d addr=%0d patt=%02h mask=%02h done at cycle %0d", op, addr, patt, mask, n);
        if (op) begin
            m_valid[addr] = 1'b0;
        end else begin
            m_valid[addr] = 1'b1;
            m_patt[addr]  = patt;
            m_mask[addr]  = mask;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wReady"}, wReady, 1);
        check({tag, "_mReady"}, mReady, 1);
        check({tag, "_wDone"}, wDone, 0);
        check({tag, "_mOutValid"}, mOutValid, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_mAddr"}, mAddr, 0);
    endtask

    initial begin
        int          k;
        logic [AW-1:0] ra;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_patt[i]  = '0;
            m_mask[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Empty table never matches
        lookup(8'hA5, 0, 1'b0, 4'd0);
        // Insert with a contending lookup: update wins
        update(1'b0, 4'd5, 8'hA5, 8'h00, 1);
        lookup(8'hA5, 0, 1'b1, 4'd5);
        lookup(8'hA4, 0, 1'b0, 4'd0);
        update(1'b0, 4'd9, 8'hA0, 8'h0F, 0);
        update(1'b0, 4'd3, 8'hA5, 8'h00, 0);
        lookup(8'hA5, 0, 1'b1, 4'd3);
        lookup(8'hAF, 0, 1'b1, 4'd9);
        lookup(8'hB5, 0, 1'b0, 4'd0);
        // Overwrite leaves no stale match rows
        update(1'b0, 4'd3, 8'h11, 8'h00, 0);
        lookup(8'hA5, 0, 1'b1, 4'd5);
        lookup(8'h11, 0, 1'b1, 4'd3);
        // Deletes ignore pattern and mask
        update(1'b1, 4'd5, 8'h5A, 8'h3C, 0);
        lookup(8'hA5, 0, 1'b1, 4'd9);
        update(1'b1, 4'd9, 8'hFF, 8'hFF, 0);
        lookup(8'hA5, 0, 1'b0, 4'd0);
        lookup(8'h11, 0, 1'b1, 4'd3);

        // Asynchronous reset in the middle of an insert of e2
        repeat (3) @(negedge clk);
        wReq  = 1'b1;
        wOp   = 1'b0;
        wAddr = 4'd2;
        wPatt = 8'hAF;
        wMask = 8'h00;
        @(posedge clk);
        #1 wReq = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lookup(8'hAF, 0, 1'b0, 4'd0);
        lookup(8'h11, 0, 1'b0, 4'd0);
        update(1'b0, 4'd2, 8'hAF, 8'h00, 0);
        lookup(8'hAF, 0, 1'b1, 4'd2);

        // Randomized phase against the model; inserts follow a lookup by one cycle
        for (int it = 0; it < 30; it++) begin
            k  = $urandom_range(0, 3);
            ra = AW'($urandom);
            if (k == 0) begin
                lookup(m_patt[ra] ^ (WIDTH'($urandom) & m_mask[ra]), 1, 1'b0, '0);
                update(1'b0, ra, WIDTH'($urandom), WIDTH'($urandom) & WIDTH'($urandom), 0);
            end else if (k == 1) begin
                update(1'b1, ra, WIDTH'($urandom), WIDTH'($urandom), 0);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    ra = AW'($urandom);
                    if ($urandom_range(0, 1) == 0)
                        lookup(m_patt[ra] ^ (WIDTH'($urandom) & m_mask[ra]), 1, 1'b0, '0);
                    else
                        lookup(WIDTH'($urandom), 1, 1'b0, '0);
                end
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
